posit_mult_stream_buf: RTL and testbench
========================================

Name: posit_mult_stream_buf

Overview:
- Credit-controlled stream wrapper placed directly downstream of the 4-stage posit multiplier. The multiplier has no stall input.
- Accepts operand pairs through a valid/ready handshake and drives the multiplier's in1/in2/start.
- Captures each result/inf/zero on done into a result FIFO, which feeds the downstream posit adder through valid/ready.
- Admits operands only while FIFO space is guaranteed for every in-flight product, so backpressure never drops a result.

Parameters:
- N, 16, posit width.
- DEPTH, 8, result FIFO entries; power of two, at least 2.
- LAT, 4, multiplier start-to-done latency in cycles; at least 1.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid&in_ready.
- in_a  in  N  operand 1.
- in_b  in  N  operand 2.
- mult_in1  out  N  to multiplier in1; combinational copy of in_a.
- mult_in2  out  N  to multiplier in2; combinational copy of in_b.
- mult_start  out  1  to multiplier start; equals in_valid&in_ready.
- mult_result  in  N  multiplier result.
- mult_inf  in  1  multiplier inf.
- mult_zero  in  1  multiplier zero.
- mult_done  in  1  multiplier done strobe.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts.
- out_data  out  N  head result.
- out_inf  out  1  head inf flag.
- out_zero  out  1  head zero flag.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data/out_inf/out_zero=0, level=0, err=0, inflight=0, FIFO pointers=0.
- State machine:
  - DRAIN: entered on reset; lasts exactly LAT cycles after reset deasserts.
    - in_ready=0.
    - mult_done is ignored, which flushes products started before reset because the multiplier pipeline is not reset.
    - Then go to RUN.
  - RUN: normal operation.
  - Reset asserted in any state, mid-operation included, returns to DRAIN and discards FIFO contents and inflight.
- inflight counter, width $clog2(DEPTH+1):
  - +1 on mult_start.
  - -1 on an accepted mult_done.
  - Both in the same cycle leaves it unchanged.
- in_ready (RUN only) = (level + inflight) < DEPTH, computed from registered values only. No combinational path from in_valid, out_ready or mult_done.
- FIFO write:
  - In RUN, mult_done writes {mult_result, mult_inf, mult_zero} at the write pointer.
  - Pointers wrap modulo DEPTH.
- FIFO read:
  - out_valid&out_ready pops the head.
  - out_data/out_inf/out_zero present the head combinationally from the storage array.
- Simultaneous write and read:
  - Allowed at any level; level is unchanged.
  - When empty, a write is visible on out_valid the next cycle; there is no fall-through.
- Full: level==DEPTH means out_valid=1 and in_ready=0. A read in that cycle lets in_ready rise the next cycle at the earliest.
- Result ordering: strictly in operand acceptance order.
- err is set, and held until reset, when in RUN either:
  - mult_done arrives with inflight==0; or
  - mult_done arrives with level==DEPTH and no simultaneous pop.
  - The offending write is dropped and counters are not corrupted.
- Throughput: one operand pair per cycle sustained while out_ready=1.

Optional Feature:
- Macro: POSIT_MBUF_NAR_CNT_EN.
- Defined:
  - Adds output nar_cnt [15:0], reset 0.
  - Increments by 1 on every FIFO write with mult_inf=1.
  - Saturates at 16'hFFFF.
  - Ignores writes dropped by DRAIN or err.
- Undefined: no port and no counter logic; the rest of the behaviour is identical.

Test Plan:
- Reset then idle:
  - Release reset.
  - in_ready stays 0 for exactly 4 cycles, rises in the 5th.
  - A mult_done pulse during DRAIN leaves level=0 and err=0.
- Single op:
  - Drive in_a=in_b=16'h4000 with in_valid; bench model returns 16'h4000 4 cycles after start.
  - out_valid rises the next cycle with out_data=16'h4000, out_inf=0, out_zero=0; level=1.
- Backpressure fill:
  - out_ready=0, in_valid held high.
  - Exactly 8 starts are issued, then in_ready=0.
  - level reaches 8 after the last done; no err.
  - Raise out_ready: 8 results drain in issue order.
- Streaming:
  - out_ready=1, 100 back-to-back pairs.
  - 100 results in order; in_ready never drops after DRAIN.
  - Max level is 1.
- Special values:
  - Inputs 16'h8000 × 16'h4000 produce out_inf=1, out_data=16'h8000.
  - 16'h0000 × 16'h0000 produces out_zero=1.
  - With the macro defined, nar_cnt=1.
- Errors and reset:
  - Inject mult_done with inflight=0: err=1, level unchanged.
  - Assert reset with 3 ops in flight and 5 queued: level=0 and err=0 next cycle; the late dones are ignored.

Source files
------------

// File: rtl/posit_mult_stream_buf.sv
// ============================================================================
// posit_mult_stream_buf -- credit-controlled result FIFO behind a fixed-latency
// posit multiplier that has no stall input.
// Optional: define POSIT_MBUF_NAR_CNT_EN to add the nar_cnt output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module posit_mult_stream_buf #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int LAT   = 4
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_a,
    input  logic [N-1:0]               in_b,
    output logic [N-1:0]               mult_in1,
    output logic [N-1:0]               mult_in2,
    output logic                       mult_start,
    input  logic [N-1:0]               mult_result,
    input  logic                       mult_inf,
    input  logic                       mult_zero,
    input  logic                       mult_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_inf,
    output logic                       out_zero,
    output logic [$clog2(DEPTH+1)-1:0] level,
`ifdef POSIT_MBUF_NAR_CNT_EN
    output logic [15:0]                nar_cnt,
`endif
    output logic                       err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [LW-1:0] C_FULL       = LW'(DEPTH);
    localparam logic [LW:0]   C_CREDITS    = (LW + 1)'(DEPTH);
    localparam logic [CW-1:0] C_DRAIN_LAST = CW'(LAT - 1);

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   drain_cnt_q;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   inflight_q, inflight_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            err_q;
    logic [N+1:0]    mem_q [DEPTH];

    logic            w_run;
    logic [LW:0]     w_committed;
    logic            w_pop;
    logic            w_full;
    logic            w_done_run;
    logic            w_err_ev;
    logic            w_push;
    logic            w_retire;
    logic [N+1:0]    w_head;

    // Products launched before reset are still in the unresettable multiplier;
    // hold off for LAT cycles so their done strobes fall into the DRAIN window.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    if (drain_cnt_q == C_DRAIN_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign w_run       = (state_q == ST_RUN);
    assign w_committed = {1'b0, level_q} + {1'b0, inflight_q};
    assign in_ready    = w_run && (w_committed < C_CREDITS);
    assign mult_start  = in_valid && in_ready;
    assign mult_in1    = in_a;
    assign mult_in2    = in_b;

    assign out_valid   = (level_q != '0);
    assign w_pop       = out_valid && out_ready;
    assign w_full      = (level_q == C_FULL);
    assign w_done_run  = w_run && mult_done;
    assign w_err_ev    = w_done_run && ((inflight_q == '0) || (w_full && !w_pop));
    assign w_push      = w_done_run && !w_err_ev;
    // A done with a live credit always retires it, even if its write was dropped.
    assign w_retire    = w_done_run && (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (mult_start && !w_retire) begin
            inflight_d = inflight_q + LW'(1);
        end else if (!mult_start && w_retire) begin
            inflight_d = inflight_q - LW'(1);
        end
    end

    always_comb begin
        level_d = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            level_q    <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            level_q    <= level_d;
            inflight_q <= inflight_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (w_err_ev) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {mult_result, mult_inf, mult_zero};
        end
    end

    assign w_head   = mem_q[rd_ptr_q];
    assign out_data = out_valid ? w_head[N+1:2] : '0;
    assign out_inf  = out_valid && w_head[1];
    assign out_zero = out_valid && w_head[0];
    assign level    = level_q;
    assign err      = err_q;

`ifdef POSIT_MBUF_NAR_CNT_EN
    logic [15:0] nar_cnt_q;

    always_ff @(posedge aclk) begin
        if (reset) begin
            nar_cnt_q <= '0;
        end else if (w_push && mult_inf && (nar_cnt_q != 16'hFFFF)) begin
            nar_cnt_q <= nar_cnt_q + 16'd1;
        end
    end

    assign nar_cnt = nar_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_mult_stream_buf.sv
// ============================================================================
// tb_posit_mult_stream_buf -- randomized self-checking bench with a behavioural
// multiplier stand-in and an in-order result scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_posit_mult_stream_buf;

    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          aclk = 1'b0;
    logic          reset, in_valid, in_ready, mult_start;
    logic [N-1:0]  in_a, in_b, mult_in1, mult_in2, mult_result, out_data;
    logic          mult_inf, mult_zero, mult_done;
    logic          out_valid, out_ready, out_inf, out_zero, err;
    logic [LW-1:0] level;
`ifdef POSIT_MBUF_NAR_CNT_EN
    logic [15:0]   nar_cnt;
`endif

    logic          inj_done, pwr_ok, streaming;
    int            errors = 0;
    int            checks = 0;
    int            pops, drops, maxlev, model_nar;
    logic [N+1:0]  exp_q [$];

    always #5 aclk = ~aclk;

    posit_mult_stream_buf #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) u_dut (
        .aclk        (aclk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mult_in1    (mult_in1),
        .mult_in2    (mult_in2),
        .mult_start  (mult_start),
        .mult_result (mult_result),
        .mult_inf    (mult_inf),
        .mult_zero   (mult_zero),
        .mult_done   (mult_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inf     (out_inf),
        .out_zero    (out_zero),
        .level       (level),
`ifdef POSIT_MBUF_NAR_CNT_EN
        .nar_cnt     (nar_cnt),
`endif
        .err         (err)
    );

    // Stand-in multiplier: NaR dominates, then zero, 1.0 is the identity,
    // anything else gets an arbitrary but deterministic tag.
    function automatic logic [N+1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a == 16'h8000 || b == 16'h8000) return {16'h8000, 2'b10};
        if (a == 16'h0000 || b == 16'h0000) return {16'h0000, 2'b01};
        if (a == 16'h4000) return {b, 2'b00};
        if (b == 16'h4000) return {a, 2'b00};
        return {a ^ {b[7:0], b[15:8]}, 2'b00};
    endfunction

    logic         pipe_v [LAT];
    logic [N+1:0] pipe_d [LAT];

    always @(posedge aclk) begin
        if (!pwr_ok) begin
            for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= mult_start;
            pipe_d[0] <= fmul(mult_in1, mult_in2);
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign mult_done   = pipe_v[LAT-1] | inj_done;
    assign mult_result = pipe_d[LAT-1][N+1:2];
    assign mult_inf    = pipe_d[LAT-1][1];
    assign mult_zero   = pipe_d[LAT-1][0];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: every accepted operand pair owes exactly one result, in order.
    always @(negedge aclk) begin
        if (reset) begin
            exp_q.delete();
            model_nar = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    check_eq("pop_order", {14'd0, out_data, out_inf, out_zero}, {14'd0, exp_q.pop_front()});
                    pops++;
                end
            end
            if (mult_start) begin
                exp_q.push_back(fmul(in_a, in_b));
                if (fmul(in_a, in_b) == {16'h8000, 2'b10}) model_nar++;
            end
            if (streaming && in_valid && !in_ready) drops++;
            if (streaming && int'(level) > maxlev) maxlev = int'(level);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int starts, lat, n;
        reset = 1; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0;
        inj_done = 0; pwr_ok = 0; streaming = 0; pops = 0; drops = 0; maxlev = 0;
        repeat (3) tick();
        pwr_ok = 1;
        tick();
        @(negedge aclk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", {out_data, out_inf, out_zero}, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_err", err, 0);

        // DRAIN window, with a stray done in its second cycle
        tick();
        reset = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge aclk);
            check_eq("drain_in_ready", in_ready, (c == 5));
            tick();
            inj_done = (c == 1);
        end
        @(negedge aclk);
        check_eq("drain_done_level", level, 0);
        check_eq("drain_done_err", err, 0);

        // single op: 1.0 x 1.0
        tick();
        in_valid = 1; in_a = 16'h4000; in_b = 16'h4000;
        @(negedge aclk);
        check_eq("single_start", mult_start, 1);
        tick();
        in_valid = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge aclk);
            if (out_valid) begin lat = k; break; end
        end
        check_eq("single_latency", lat, 5);
        check_eq("single_data", out_data, 16'h4000);
        check_eq("single_flags", {out_inf, out_zero}, 0);
        check_eq("single_level", level, 1);
        tick(); out_ready = 1;
        @(negedge aclk);
        tick(); out_ready = 0;
        @(negedge aclk);
        check_eq("single_drained", level, 0);

        // backpressure fill
        tick();
        starts = 0; in_valid = 1;
        for (int k = 0; k < 20; k++) begin
            in_a = N'($urandom); in_b = N'($urandom);
            @(negedge aclk);
            if (mult_start) starts++;
            tick();
        end
        in_valid = 0;
        @(negedge aclk);
        check_eq("fill_starts", starts, DEPTH);
        check_eq("fill_in_ready", in_ready, 0);
        check_eq("fill_level", level, DEPTH);
        check_eq("fill_err", err, 0);
        tick(); out_ready = 1;
        for (int k = 0; k < 20 && level != 0; k++) begin
            @(negedge aclk);
            tick();
        end
        @(negedge aclk);
        check_eq("fill_drained", level, 0);

        // streaming
        tick();
        pops = 0; starts = 0; n = 0; streaming = 1; in_valid = 1;
        while (starts < 100 && n < 300) begin
            in_a = N'($urandom); in_b = N'($urandom);
            @(negedge aclk);
            if (mult_start) starts++;
            n++;
            tick();
        end
        in_valid = 0; streaming = 0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge aclk);
            tick();
        end
        check_eq("stream_starts", starts, 100);
        check_eq("stream_pops", pops, 100);
        check_eq("stream_ready_drops", drops, 0);
        check_eq("stream_max_level", maxlev, 1);

        // random valid/ready mix
        for (int k = 0; k < 200; k++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            in_a = N'($urandom); in_b = N'($urandom);
            if ($urandom_range(0, 15) == 0) in_a = 16'h8000;
            tick();
        end
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        @(negedge aclk);
        check_eq("mix_empty", exp_q.size(), 0);
        check_eq("mix_level", level, 0);
        check_eq("mix_err", err, 0);

        // special values
        tick();
        out_ready = 0; in_valid = 1; in_a = 16'h8000; in_b = 16'h4000;
        @(negedge aclk);
        tick();
        in_a = 16'h0000; in_b = 16'h0000;
        @(negedge aclk);
        tick();
        in_valid = 0;
        for (int k = 0; k < 20 && level != 2; k++) tick();
        @(negedge aclk);
        check_eq("nar_data", out_data, 16'h8000);
        check_eq("nar_flags", {out_inf, out_zero}, 2'b10);
        tick(); out_ready = 1;
        @(negedge aclk);
        tick(); out_ready = 0;
        @(negedge aclk);
        check_eq("zero_data", out_data, 16'h0000);
        check_eq("zero_flags", {out_inf, out_zero}, 2'b01);
        tick(); out_ready = 1;
        @(negedge aclk);
        tick(); out_ready = 0;
`ifdef POSIT_MBUF_NAR_CNT_EN
        @(negedge aclk);
        check_eq("nar_cnt", nar_cnt, model_nar);
`endif

        // stray done with nothing in flight
        @(negedge aclk);
        tick(); inj_done = 1;
        @(negedge aclk);
        tick(); inj_done = 0;
        @(negedge aclk);
        check_eq("stray_err", err, 1);
        check_eq("stray_level", level, 0);

        // reset clears err, then reset with 5 queued and 3 in flight
        tick(); reset = 1;
        tick();
        @(negedge aclk);
        check_eq("rst2_err", err, 0);
        tick(); reset = 0;
        for (int k = 0; k < 10 && !in_ready; k++) tick();
        starts = 0; in_valid = 1;
        for (int k = 0; k < 20 && starts < 5; k++) begin
            in_a = N'($urandom); in_b = N'($urandom);
            @(negedge aclk);
            if (mult_start) starts++;
            tick();
        end
        in_valid = 0;
        for (int k = 0; k < 20 && level != 5; k++) tick();
        @(negedge aclk);
        check_eq("mid_queued", level, 5);
        tick(); in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            in_a = N'($urandom); in_b = N'($urandom);
            @(negedge aclk);
            check_eq("mid_start", mult_start, 1);
            tick();
        end
        in_valid = 0; reset = 1;
        tick();
        @(negedge aclk);
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        tick(); reset = 0;
        repeat (LAT + 2) tick();
        @(negedge aclk);
        check_eq("late_done_level", level, 0);
        check_eq("late_done_err", err, 0);
`ifdef POSIT_MBUF_NAR_CNT_EN
        check_eq("late_nar_cnt", nar_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
